// File: rtl/motor_pkg.sv
// motor_pkg: shared direction constants, scheduler state type and command helpers
package motor_pkg;
  localparam logic [3:0] STOP = 4'h0;
  localparam logic [3:0] UP = 4'h1;
  localparam logic [3:0] DOWN = 4'h2;
  localparam logic [3:0] LEFT = 4'h4;
  localparam logic [3:0] RIGHT = 4'h8;
  localparam int FAST_BIT = 6;
  localparam logic [7:0] DIR_MASK = 8'h0F;
  typedef enum logic [2:0] {IDLE, DEAD, RUN_MAN, RUN_AUTO, ESTOP} state_t;
  function automatic logic is_legal_dir(input logic [3:0] d);
    return d inside {UP, DOWN, LEFT, RIGHT};
  endfunction
  function automatic logic [7:0] fwd_cmd(input logic [7:0] cmd);
    return cmd & (DIR_MASK | 8'(1 << FAST_BIT));
  endfunction
endpackage

// File: rtl/motor_cmd_sched_cycle_timer.sv
// cycle_timer: loadable down-counter that flags its final cycle and then parks at zero
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_tick,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (i_tick && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end
  assign o_done = r_cnt == W'(1);
endmodule

// File: rtl/motor_cmd_sched.sv
// motor_cmd_sched: arbitrates estop, keypad and timed autonomous commands onto key_state,
// forcing a stop dead-time before any new direction reaches the H-bridge.
module motor_cmd_sched
  import motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 50000,
  parameter int DUR_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             estop,
  input  logic             man_valid,
  input  logic [7:0]       man_cmd,
  input  logic             auto_valid,
  output logic             auto_ready,
  input  logic [7:0]       auto_cmd,
  input  logic [DUR_W-1:0] auto_dur,
  output logic             auto_done,
  output logic             auto_abort,
  output logic [7:0]       key_state,
  output logic             busy
);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  state_t r_state;
  logic [7:0] r_key, r_auto_cmd;
  logic [3:0] r_dir;
  logic r_tgt_auto, r_done, r_abort;
  logic w_manreq, w_dir_chg, w_acc, w_auto_ok, w_auto_act, w_dead_load, w_dead_done, w_dur_done;
  assign w_manreq = man_valid && is_legal_dir(man_cmd[3:0]);
  assign w_dir_chg = man_cmd[3:0] != r_dir;
  assign auto_ready = rst && r_state == IDLE && !estop && !w_manreq;
  assign w_acc = auto_valid && auto_ready;
  assign w_auto_ok = is_legal_dir(auto_cmd[3:0]) && auto_dur != '0;
  assign w_auto_act = r_state == RUN_AUTO || (r_state == DEAD && r_tgt_auto);
  // every entry into DEAD, or a restart while already there, reloads the dead-time
  assign w_dead_load = !estop && (r_state == IDLE ? w_manreq || (w_acc && w_auto_ok)
                     : w_manreq && (w_auto_act || (r_state inside {DEAD, RUN_MAN} && w_dir_chg)));
  cycle_timer #(.W(DW)) u_dead (
    .i_clk(clk), .i_rst_n(rst), .i_load(w_dead_load), .i_value(DW'(DEAD_CYCLES)),
    .i_tick(r_state == DEAD), .o_done(w_dead_done)
  );
  cycle_timer #(.W(DUR_W)) u_dur (
    .i_clk(clk), .i_rst_n(rst), .i_load(w_acc), .i_value(auto_dur),
    .i_tick(r_state == RUN_AUTO), .o_done(w_dur_done)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_key <= '0;
      r_auto_cmd <= '0;
      r_dir <= STOP;
      r_tgt_auto <= 1'b0;
      r_done <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_abort <= 1'b0;
      if (estop) begin
        r_state <= ESTOP;
        r_key <= '0;
        r_done <= w_auto_act;
        r_abort <= w_auto_act;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_manreq) begin
              r_state <= DEAD;
              r_tgt_auto <= 1'b0;
              r_dir <= man_cmd[3:0];
            end else if (w_acc) begin
              r_auto_cmd <= fwd_cmd(auto_cmd);
              r_tgt_auto <= 1'b1;
              r_state <= w_auto_ok ? DEAD : IDLE;
              r_done <= !w_auto_ok;
            end
          end
          DEAD: begin
            if (r_tgt_auto && w_manreq) begin
              r_done <= 1'b1;
              r_abort <= 1'b1;
              r_tgt_auto <= 1'b0;
              r_dir <= man_cmd[3:0];
            end else if (!r_tgt_auto && !w_manreq) begin
              r_state <= IDLE;
            end else if (!r_tgt_auto && w_dir_chg) begin
              r_dir <= man_cmd[3:0];
            end else if (w_dead_done) begin
              r_state <= r_tgt_auto ? RUN_AUTO : RUN_MAN;
              r_key <= r_tgt_auto ? r_auto_cmd : fwd_cmd(man_cmd);
            end
          end
          RUN_MAN: begin
            if (!w_manreq) begin
              r_state <= IDLE;
              r_key <= '0;
            end else if (w_dir_chg) begin
              r_state <= DEAD;
              r_key <= '0;
              r_dir <= man_cmd[3:0];
            end else begin
              r_key <= fwd_cmd(man_cmd);
            end
          end
          RUN_AUTO: begin
            if (w_manreq) begin
              r_state <= DEAD;
              r_key <= '0;
              r_tgt_auto <= 1'b0;
              r_dir <= man_cmd[3:0];
              r_done <= 1'b1;
              r_abort <= 1'b1;
            end else if (w_dur_done) begin
              r_state <= IDLE;
              r_key <= '0;
              r_done <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign key_state = r_key;
  assign auto_done = r_done;
  assign auto_abort = r_abort;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_motor_cmd_sched.sv
// tb_motor_cmd_sched: randomized scenarios; expected key_state/auto_done events are queued
// with their edge number and a negedge monitor pops and compares each observed event.
module tb_motor_cmd_sched;
  localparam int DC = 4;
  localparam int DW = 24;
  localparam logic [7:0] M = 8'h4F;
  typedef struct {int cyc; logic [7:0] key; logic done; logic abort;} ev_t;
  logic clk = 1'b0, rst = 1'b0, estop = 1'b0, man_valid = 1'b0, auto_valid = 1'b0;
  logic [7:0] man_cmd = '0, auto_cmd = '0;
  logic [DW-1:0] auto_dur = '0;
  logic auto_ready, auto_done, auto_abort, busy;
  logic [7:0] key_state;
  logic [7:0] prev_key = '0;
  int cyc = 0, checks = 0, errors = 0;
  ev_t sb[$];
  ev_t mon_e;
  motor_cmd_sched #(.DEAD_CYCLES(DC), .DUR_W(DW)) dut (
    .clk(clk), .rst(rst), .estop(estop), .man_valid(man_valid), .man_cmd(man_cmd),
    .auto_valid(auto_valid), .auto_ready(auto_ready), .auto_cmd(auto_cmd), .auto_dur(auto_dur),
    .auto_done(auto_done), .auto_abort(auto_abort), .key_state(key_state), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst && (key_state !== prev_key || auto_done !== 1'b0 || auto_abort !== 1'b0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cycle %0d key %02h done %b abort %b, required no event", cyc, key_state, auto_done, auto_abort);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.key !== key_state || mon_e.done !== auto_done || mon_e.abort !== auto_abort) begin
          errors++;
          $display("FAIL event: got cycle %0d key %02h done %b abort %b, required cycle %0d key %02h done %b abort %b",
                   cyc, key_state, auto_done, auto_abort, mon_e.cyc, mon_e.key, mon_e.done, mon_e.abort);
        end
      end
    end
    prev_key = key_state;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: still running at cycle %0d, required finish", cyc);
    $fatal(1, "timeout");
  end
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  task automatic push_ev(int c, logic [7:0] k, logic d, logic a);
    sb.push_back('{c, k, d, a});
  endtask
  function automatic bit legal(logic [7:0] c);
    return c[3:0] inside {4'h1, 4'h2, 4'h4, 4'h8};
  endfunction
  function automatic logic [3:0] rdir();
    return 4'(1 << $urandom_range(0, 3));
  endfunction
  function automatic logic [7:0] rcmd(logic [3:0] d);
    logic [7:0] r;
    r = 8'($urandom);
    r[3:0] = d;
    return r;
  endfunction
  task automatic man_drive(logic [7:0] c1, logic [7:0] c2, logic [7:0] c3, int h);
    int t;
    man_valid = 1'b1;
    man_cmd = c1;
    t = cyc + 1;
    push_ev(t + DC, c1 & M, 1'b0, 1'b0);
    repeat (DC + h) @(negedge clk);
    man_cmd = c2;
    if ((c2 & M) != (c1 & M)) push_ev(cyc + 1, c2 & M, 1'b0, 1'b0);
    repeat (h) @(negedge clk);
    man_cmd = c3;
    t = cyc + 1;
    push_ev(t, 8'h00, 1'b0, 1'b0);
    push_ev(t + DC, c3 & M, 1'b0, 1'b0);
    repeat (DC + h) @(negedge clk);
    man_valid = 1'b0;
    push_ev(cyc + 1, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_man_off", busy, 0);
  endtask
  task automatic man_dead(logic [7:0] c1, logic [7:0] c2, int k, bit drop);
    man_valid = 1'b1;
    man_cmd = c1;
    repeat (k) @(negedge clk);
    if (drop) begin
      man_valid = 1'b0;
      @(negedge clk);
      chk("busy_dead_drop", busy, 0);
    end else begin
      man_cmd = c2;
      push_ev(cyc + 1 + DC, c2 & M, 1'b0, 1'b0);
      repeat (DC + 1) @(negedge clk);
      man_valid = 1'b0;
      push_ev(cyc + 1, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("busy_dead_chg", busy, 0);
    end
  endtask
  // mode 0: run to completion, 1: manual preemption at t+off, 2: estop at t+off
  task automatic auto_run(logic [7:0] c, int dur, int mode, int off, logic [7:0] mc);
    int t, tp;
    bit ok;
    chk("ready_idle", auto_ready, 1);
    ok = legal(c) && dur != 0;
    auto_valid = 1'b1;
    auto_cmd = c;
    auto_dur = DW'(dur);
    t = cyc + 1;
    tp = t + off;
    if (!ok) push_ev(t, 8'h00, 1'b1, 1'b0);
    else if (mode == 0) begin
      push_ev(t + DC, c & M, 1'b0, 1'b0);
      push_ev(t + DC + dur, 8'h00, 1'b1, 1'b0);
    end else begin
      if (tp > t + DC) push_ev(t + DC, c & M, 1'b0, 1'b0);
      push_ev(tp, 8'h00, 1'b1, 1'b1);
      if (mode == 1) push_ev(tp + DC, mc & M, 1'b0, 1'b0);
    end
    @(negedge clk);
    auto_valid = 1'b0;
    if (!ok) begin
      chk("busy_reject", busy, 0);
      @(negedge clk);
    end else if (mode == 0) begin
      while (cyc < t + DC + dur) begin
        chk("ready_auto", auto_ready, 0);
        @(negedge clk);
      end
      chk("busy_auto_end", busy, 0);
    end else begin
      while (cyc < tp - 1) begin
        chk("ready_auto", auto_ready, 0);
        @(negedge clk);
      end
      if (mode == 1) begin
        man_valid = 1'b1;
        man_cmd = mc;
      end else estop = 1'b1;
      repeat (DC + 2) begin
        @(negedge clk);
        chk("ready_preempt", auto_ready, 0);
        if (mode == 2) chk("busy_estop", busy, 1);
      end
      if (mode == 1) begin
        man_valid = 1'b0;
        push_ev(cyc + 1, 8'h00, 1'b0, 1'b0);
      end else estop = 1'b0;
      @(negedge clk);
      chk("busy_release", busy, 0);
    end
  endtask
  task automatic reset_mid_dead(int k);
    auto_valid = 1'b1;
    auto_cmd = 8'h42;
    auto_dur = DW'(5);
    @(negedge clk);
    auto_valid = 1'b0;
    repeat (k) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_key", key_state, 0);
    chk("rst_mid_ready", auto_ready, 0);
    chk("rst_mid_done", {auto_done, auto_abort}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (DC + 7) @(negedge clk);
    chk("rst_mid_after", busy, 0);
  endtask
  initial begin
    logic [3:0] d1, d3;
    logic [7:0] c1, c2;
    int dur;
    repeat (3) @(negedge clk);
    chk("rst_key", key_state, 0);
    chk("rst_ready", auto_ready, 0);
    chk("rst_done", auto_done, 0);
    chk("rst_abort", auto_abort, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    man_drive(8'h01, 8'h41, 8'h02, 3);
    auto_run(8'h48, 10, 0, 0, 8'h00);
    auto_run(8'h48, 0, 0, 0, 8'h00);
    auto_run(8'h03, 10, 0, 0, 8'h00);
    auto_run(8'h48, 10, 1, DC + 3, 8'h04);
    auto_run(8'h48, 10, 2, DC + 2, 8'h00);
    estop = 1'b1;
    @(negedge clk);
    chk("estop_idle_ready", auto_ready, 0);
    chk("estop_idle_busy", busy, 1);
    estop = 1'b0;
    @(negedge clk);
    chk("estop_idle_release", busy, 0);
    reset_mid_dead(1);
    man_dead(8'h01, 8'h08, 2, 1'b0);
    man_dead(8'h04, 8'h00, 1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      d1 = rdir();
      do d3 = rdir(); while (d3 == d1);
      c1 = rcmd(d1);
      dur = $urandom_range(1, 12);
      case ($urandom_range(0, 5))
        0: begin
          c2 = rcmd(d1);
          c2[6] = ~c1[6];
          man_drive(c1, c2, rcmd(d3), $urandom_range(1, 4));
        end
        1: man_dead(c1, rcmd(d3), $urandom_range(1, DC - 1), 1'($urandom));
        2: auto_run(c1, dur, 0, 0, 8'h00);
        3: begin
          c2 = 8'($urandom);
          if ($urandom_range(0, 1) == 0) auto_run(c1, 0, 0, 0, 8'h00);
          else if (!legal(c2)) auto_run(c2, dur, 0, 0, 8'h00);
          else auto_run(c2 & 8'hF0, dur, 0, 0, 8'h00);
        end
        4: auto_run(c1, dur, 1, $urandom_range(1, DC + dur), rcmd(d3));
        default: auto_run(c1, dur, 2, $urandom_range(1, DC + dur), 8'h00);
      endcase
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
